// File: rtl/sram_bus_ctrl.sv
// Sequences CE/OE/WE strobes for an async SRAM with WAIT_CYCLES wait states; owns the data-bus tristate.
// Latency: accept edge to ack is WAIT_CYCLES for reads, WAIT_CYCLES+2 for writes; ack is a one-cycle pulse.
// Backpressure: req is sampled only while idle (busy=0); requests during busy are dropped, the core re-issues.
// Optional SRAM_BYTE_EN adds be[1:0] driving UB_out/LB_out; without it both lanes are enabled with CE_out.
module sram_bus_ctrl #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
`ifdef SRAM_BYTE_EN
    input  logic [1:0]        be,
`endif
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic [ADDR_W-1:0] A,
    output logic              CE_out,
    output logic              OE_out,
    output logic              WE_out,
    output logic              UB_out,
    output logic              LB_out,
    inout  wire  [DATA_W-1:0] Mem_bus
);

    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              ce_q, ce_d, oe_q, oe_d, we_q, we_d;
    logic              ub_q, ub_d, lb_q, lb_d;
    logic              drv_q, drv_d;
    logic [1:0]        lanes_n;

    // Active-low byte-lane strobes chosen at accept time and held for the whole access.
`ifdef SRAM_BYTE_EN
    assign lanes_n = ~be;
`else
    assign lanes_n = 2'b00;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        ce_d    = ce_q;
        oe_d    = oe_q;
        we_d    = we_q;
        ub_d    = ub_q;
        lb_d    = lb_q;
        drv_d   = drv_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    a_d          = addr;
                    wdata_d      = wdata;
                    cnt_d        = CNT_LOAD;
                    ce_d         = 1'b0;
                    {ub_d, lb_d} = lanes_n;
                    if (we) begin
                        state_d = WR_SETUP;
                        drv_d   = 1'b1;
                    end else begin
                        state_d = RD;
                        oe_d    = 1'b0;
                    end
                end
            end
            RD: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = Mem_bus;
                    ack_d   = 1'b1;
                    ce_d    = 1'b1;
                    oe_d    = 1'b1;
                    ub_d    = 1'b1;
                    lb_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_SETUP: begin
                we_d    = 1'b0;
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_q == 4'd0) begin
                    we_d    = 1'b1;
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_HOLD: begin
                // Data stays driven one cycle past the WE rising edge for hold time.
                ce_d    = 1'b1;
                ub_d    = 1'b1;
                lb_d    = 1'b1;
                drv_d   = 1'b0;
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_q     <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            ce_q    <= 1'b1;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            ub_q    <= 1'b1;
            lb_q    <= 1'b1;
            drv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            ce_q    <= ce_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            ub_q    <= ub_d;
            lb_q    <= lb_d;
            drv_q   <= drv_d;
        end
    end

    assign Mem_bus = drv_q ? wdata_q : 'z;
    assign rdata   = rdata_q;
    assign ack     = ack_q;
    assign busy    = (state_q != IDLE);
    assign A       = a_q;
    assign CE_out  = ce_q;
    assign OE_out  = oe_q;
    assign WE_out  = we_q;
    assign UB_out  = ub_q;
    assign LB_out  = lb_q;

endmodule
